duty_slew: RTL and testbench
============================

Name: duty_slew

Overview:
- Upstream setpoint stage for the pwm block; its pw output drives pwm's 8-bit PW input directly.
- Accepts a target duty through a valid/ready handshake.
- Slews the applied duty toward the target by a fixed step once per update tick, so the motor stage never sees a duty jump.
- Provides an immediate kill path that forces the duty to 0.

Parameters:
- STEP_DIV, 4864, clocks per update tick; equals one pwm frame (256 x 19 clocks); legal range >= 1.
- STEP, 1, duty increment/decrement per tick; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- target  input  8  requested duty, 0..255.
- target_valid  input  1  target is presented this cycle.
- target_ready  output  1  block accepts a target this cycle.
- kill  input  1  level-sensitive emergency off.
- pw  output  8  applied duty; connects to pwm PW.
- busy  output  1  high while ramping.
- at_target  output  1  high when pw equals the latched target and the block is not in FAULT.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pw=0, target_reg=0, tick counter=0, state=IDLE.
  - target_ready=0, busy=0, at_target=0.
  - All outputs are registered. target_ready rises on the first clk edge after rst_n deasserts; at_target rises on that same edge.
- Tick divider:
  - Free-running counter 0..STEP_DIV-1, width clog2(STEP_DIV), minimum 1 bit.
  - tick is high in the cycle where count==STEP_DIV-1; the counter wraps to 0 on the next edge.
  - The counter is never reset by handshakes or by kill, only by rst_n.
- States: IDLE, RAMP, FAULT.
  - IDLE: pw==target_reg; target_ready=1; at_target=1; busy=0.
  - RAMP: pw!=target_reg; target_ready=1; busy=1; at_target=0.
  - FAULT: pw=0; target_ready=0; busy=0; at_target=0.
- Handshake:
  - Accept when target_valid && target_ready at a clk edge: target_reg <= target.
  - Next state is RAMP if target != pw, else IDLE.
  - Re-targeting mid-ramp is legal. Direction is recomputed from the new target_reg.
  - target_valid while target_ready=0 is ignored, with no buffering.
- Slew, on a tick edge in RAMP with no accept on that edge:
  - If pw < target_reg: pw <= min(pw+STEP, target_reg), sum computed 9 bits wide.
  - Else: pw <= max(pw-STEP, target_reg), computed signed or with a borrow check. No wrap-around below 0 or above 255.
  - If the new pw equals target_reg, state goes to IDLE on the same edge; at_target is high from that edge.
- Priority:
  - Simultaneous accept and tick: the accept wins; no step is taken that cycle; the next step occurs on the next tick.
  - kill overrides everything.
- Kill:
  - kill high at an edge, in any state: pw <= 0, target_reg <= 0, state <= FAULT.
  - Any target presented on that edge is discarded.
  - Stay in FAULT while kill is high.
  - First edge with kill low: state <= IDLE (pw=0, target_reg=0, target_ready=1).
- Boundaries:
  - target 0 or 255 is reached by ordinary stepping; pwm handles the 0/255 special cases.
  - STEP=255 gives a full swing in one tick.
  - Re-issuing target==pw in IDLE stays in IDLE with no output change.
- Reset mid-ramp: immediate return to reset values; no step completes.

Test Plan (sim parameters STEP_DIV=4, STEP=10 unless noted):
1. Reset:
   - Hold rst_n low 3 clocks -> pw=0, target_ready=0, busy=0, at_target=0.
   - Release -> target_ready=1 and at_target=1 on the first edge.
2. Ramp up:
   - Accept target=25 -> busy=1; pw goes 10, 20, 25 on successive ticks (4 clocks apart).
   - The final step clamps to 25 -> at_target=1, busy=0.
3. Ramp down and retarget:
   - From pw=25, accept 0 -> pw 15, 5, 0.
   - Then accept 200; at pw=20 accept 5 -> pw 10, 5; IDLE.
4. Accept/tick collision:
   - Assert target_valid in the tick cycle -> target latched, pw unchanged that edge.
   - Step applied on the following tick only.
5. Kill:
   - At pw=50 mid-ramp, assert kill with target_valid=1 target=90 -> next edge pw=0, target_ready=0, state FAULT; target discarded.
   - Hold kill 10 clocks -> pw stays 0.
   - Deassert -> IDLE, ready=1, pw=0.
6. Full swing and reset mid-ramp:
   - With STEP=255, accept 255 -> pw=255 at the first tick.
   - With STEP=10, pull rst_n low at pw=30 while ramping to 100 -> pw=0 asynchronously, target_ready=0.

Source files
------------

// File: rtl/duty_slew.sv
// duty_slew: slews an applied pwm duty toward a handshaked target, with an immediate kill to zero
module duty_slew #(
    parameter int STEP_DIV = 4864,
    parameter int STEP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target,
    input  logic       target_valid,
    output logic       target_ready,
    input  logic       kill,
    output logic [7:0] pw,
    output logic       busy,
    output logic       at_target
);
    localparam int            CW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST  = CW'(STEP_DIV - 1);
    localparam logic [8:0]    STEP9 = 9'(STEP);
    localparam logic [1:0]    IDLE  = 2'd0;
    localparam logic [1:0]    RAMP  = 2'd1;
    localparam logic [1:0]    FAULT = 2'd2;

    logic [CW-1:0] cnt;
    logic [1:0]    state, state_n;
    logic [7:0]    target_reg, tr_n, pw_n, up, dn, slew;
    logic [8:0]    sum, diff;
    logic          tick, accept;

    assign tick   = (cnt == LAST);
    assign accept = target_valid && target_ready;
    // 9-bit sum/difference so a step can never wrap past 255 or below 0
    assign sum    = {1'b0, pw} + STEP9;
    assign diff   = {1'b0, pw} - STEP9;
    assign up     = (sum > {1'b0, target_reg}) ? target_reg : sum[7:0];
    assign dn     = (diff[8] || diff[7:0] < target_reg) ? target_reg : diff[7:0];
    assign slew   = (pw < target_reg) ? up : dn;

    // free-running update-tick divider, only reset by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= tick ? '0 : cnt + CW'(1);
    end

    // next-state selection: kill, then fault exit, then accept, then slew step
    always_comb begin
        pw_n    = pw;
        tr_n    = target_reg;
        state_n = state;
        if (kill) begin
            pw_n    = 8'd0;
            tr_n    = 8'd0;
            state_n = FAULT;
        end else if (state == FAULT) begin
            state_n = IDLE;
        end else if (accept) begin
            tr_n    = target;
            state_n = (target != pw) ? RAMP : IDLE;
        end else if (tick && state == RAMP) begin
            pw_n    = slew;
            state_n = (slew == target_reg) ? IDLE : RAMP;
        end
    end

    // state, duty and registered status flags derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pw           <= 8'd0;
            target_reg   <= 8'd0;
            target_ready <= 1'b0;
            busy         <= 1'b0;
            at_target    <= 1'b0;
        end else begin
            state        <= state_n;
            pw           <= pw_n;
            target_reg   <= tr_n;
            target_ready <= (state_n != FAULT);
            busy         <= (state_n == RAMP);
            at_target    <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_duty_slew.sv
// tb_duty_slew: directed and random checks of duty_slew against an arithmetic reference model
module tb_duty_slew;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] target = 8'd0;
    logic       target_valid = 1'b0;
    logic       kill = 1'b0;
    logic [7:0] pw_a, pw_b;
    logic       rdy_a, rdy_b, busy_a, busy_b, at_a, at_b;

    int checks = 0;
    int errors = 0;

    // reference model: same inputs drive both instances, only the step differs
    int m_pw[2];
    int m_tr[2];
    int m_step[2] = '{10, 255};
    int m_cnt;
    bit m_fault, m_fresh;
    int seen[$];
    int exp_q[$];

    always #5 clk = ~clk;

    duty_slew #(.STEP_DIV(4), .STEP(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .target(target), .target_valid(target_valid),
        .target_ready(rdy_a), .kill(kill), .pw(pw_a), .busy(busy_a), .at_target(at_a)
    );

    duty_slew #(.STEP_DIV(4), .STEP(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .target(target), .target_valid(target_valid),
        .target_ready(rdy_b), .kill(kill), .pw(pw_b), .busy(busy_b), .at_target(at_b)
    );

    function automatic bit e_ready();
        return !m_fresh && !m_fault;
    endfunction

    function automatic bit e_busy(int i);
        return e_ready() && (m_pw[i] != m_tr[i]);
    endfunction

    function automatic bit e_at(int i);
        return e_ready() && (m_pw[i] == m_tr[i]);
    endfunction

    task automatic model_reset();
        m_pw    = '{0, 0};
        m_tr    = '{0, 0};
        m_cnt   = 0;
        m_fault = 1'b0;
        m_fresh = 1'b1;
    endtask

    task automatic model_edge();
        bit tick, acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = (m_cnt % 4) == 3;
        acc  = target_valid && e_ready();
        for (int i = 0; i < 2; i++) begin
            if (kill) begin
                m_pw[i] = 0;
                m_tr[i] = 0;
            end else if (m_fault) begin
            end else if (acc) begin
                m_tr[i] = int'(target);
            end else if (tick && m_pw[i] != m_tr[i]) begin
                if (m_pw[i] < m_tr[i])
                    m_pw[i] = (m_pw[i] + m_step[i] > m_tr[i]) ? m_tr[i] : m_pw[i] + m_step[i];
                else
                    m_pw[i] = (m_pw[i] - m_step[i] < m_tr[i]) ? m_tr[i] : m_pw[i] - m_step[i];
            end
        end
        m_fault = kill;
        m_fresh = 1'b0;
        m_cnt++;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pw_a", int'(pw_a), m_pw[0]);
        chk("pw_b", int'(pw_b), m_pw[1]);
        chk("ready_a", int'(rdy_a), int'(e_ready()));
        chk("ready_b", int'(rdy_b), int'(e_ready()));
        chk("busy_a", int'(busy_a), int'(e_busy(0)));
        chk("busy_b", int'(busy_b), int'(e_busy(1)));
        chk("at_a", int'(at_a), int'(e_at(0)));
        chk("at_b", int'(at_b), int'(e_at(1)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input int t);
        target       = 8'(t);
        target_valid = 1'b1;
        cyc();
        target_valid = 1'b0;
    endtask

    task automatic wait_a(input int v);
        int n = 0;
        while (int'(pw_a) != v && n < 300) begin
            cyc();
            n++;
        end
        chk("wait_pw_a", int'(pw_a), v);
    endtask

    task automatic trace_a();
        int n = 0;
        int last = int'(pw_a);
        seen.delete();
        while (e_busy(0) && n < 300) begin
            cyc();
            if (int'(pw_a) != last) seen.push_back(int'(pw_a));
            last = int'(pw_a);
            n++;
        end
        chk("trace_len", seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
            chk("trace_val", seen[i], exp_q[i]);
    endtask

    initial begin
        model_reset();
        // reset held for three clocks
        #1 check_all();
        repeat (3) cyc();
        chk("rst_ready", int'(rdy_a), 0);
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", int'(rdy_a), 1);
        chk("rel_at", int'(at_a), 1);
        // ramp up with clamped final step
        send(25);
        chk("ramp_busy", int'(busy_a), 1);
        exp_q = '{10, 20, 25};
        trace_a();
        chk("up_at", int'(at_a), 1);
        chk("up_busy", int'(busy_a), 0);
        // ramp down, then retarget mid-ramp
        send(0);
        exp_q = '{15, 5, 0};
        trace_a();
        send(200);
        wait_a(20);
        send(5);
        exp_q = '{10, 5};
        trace_a();
        chk("retarget_at", int'(at_a), 1);
        // re-issuing the current duty stays idle
        send(5);
        chk("same_busy", int'(busy_a), 0);
        chk("same_pw", int'(pw_a), 5);
        // accept on a tick edge: latch only, step on the following tick
        for (int n = 0; n < 8 && (m_cnt % 4) != 3; n++) cyc();
        send(45);
        chk("coll_pw", int'(pw_a), 5);
        repeat (3) begin
            cyc();
            chk("coll_hold", int'(pw_a), 5);
        end
        cyc();
        chk("coll_step", int'(pw_a), 15);
        // kill mid-ramp with a target presented on the same edge
        send(0);
        wait_a(0);
        send(200);
        wait_a(50);
        kill = 1'b1;
        send(90);
        chk("kill_pw", int'(pw_a), 0);
        chk("kill_ready", int'(rdy_a), 0);
        chk("kill_busy", int'(busy_a), 0);
        repeat (10) begin
            cyc();
            chk("kill_hold", int'(pw_a), 0);
        end
        kill = 1'b0;
        cyc();
        chk("unkill_ready", int'(rdy_a), 1);
        chk("unkill_at", int'(at_a), 1);
        chk("unkill_pw", int'(pw_a), 0);
        // full swing in one tick on the wide-step instance
        send(255);
        for (int n = 0; n < 8 && m_pw[1] == 0; n++) cyc();
        chk("swing_b", int'(pw_b), 255);
        chk("swing_a", int'(pw_a), 10);
        // asynchronous reset mid-ramp
        send(100);
        wait_a(30);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_pw", int'(pw_a), 0);
        chk("arst_ready", int'(rdy_a), 0);
        check_all();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        // random traffic
        for (int n = 0; n < 600; n++) begin
            target       = 8'($urandom);
            target_valid = ($urandom % 3) == 0;
            kill         = kill ? (($urandom % 4) != 0) : (($urandom % 50) == 0);
            cyc();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
